// File: rtl/rotary_encoder_ctrl.sv
// rotary_encoder_ctrl: synchronised, filtered rotary encoder decoder with bounded position counter and debounced key.
module rotary_encoder_filt #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic flip
);
  localparam int W = $clog2(LEN + 1);
  logic [W-1:0] c;
  // flip marks the edge on which q takes the new level
  assign flip = (d != q) && (c == W'(LEN - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= 1'b1;
      c <= '0;
    end else begin
      q <= flip ? d : q;
      c <= (d != q && !flip) ? c + 1'b1 : '0;
    end
endmodule

module rotary_encoder_ctrl #(
  parameter int CNT_W    = 8,
  parameter int CNT_MIN  = 0,
  parameter int CNT_MAX  = 255,
  parameter bit WRAP     = 1'b1,
  parameter int FILT_LEN = 4,
  parameter int KEY_DB   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s1,
  input  logic             s2,
  input  logic             key,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             key_level,
  output logic             key_press
);
  typedef enum logic [1:0] {IDLE, ARMED, DETECT, RELEASE} state_t;
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);
  logic [1:0] s1_sy, s2_sy, key_sy;
  logic fs1, fs2, kd, fs1_flip, fs2_flip, kd_flip;
  logic cw, ccw;
  logic [CNT_W-1:0] cnt_up, cnt_dn;
  state_t state, nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_sy  <= '1;
      s2_sy  <= '1;
      key_sy <= '1;
    end else begin
      s1_sy  <= {s1_sy[0], s1};
      s2_sy  <= {s2_sy[0], s2};
      key_sy <= {key_sy[0], key};
    end
  rotary_encoder_filt #(.LEN(FILT_LEN)) u_f1 (.clk(clk), .rst(rst), .d(s1_sy[1]), .q(fs1), .flip(fs1_flip));
  rotary_encoder_filt #(.LEN(FILT_LEN)) u_f2 (.clk(clk), .rst(rst), .d(s2_sy[1]), .q(fs2), .flip(fs2_flip));
  rotary_encoder_filt #(.LEN(KEY_DB))   u_fk (.clk(clk), .rst(rst), .d(key_sy[1]), .q(kd), .flip(kd_flip));
  always_comb begin
    nxt = state;
    cw  = 1'b0;
    ccw = 1'b0;
    case (state)
      IDLE:   nxt = ARMED;
      ARMED:  nxt = fs2 ? ARMED : DETECT;
      DETECT: begin
        cw  = fs2 & ~fs1;
        ccw = fs2 & fs1;
        nxt = fs2 ? RELEASE : DETECT;
      end
      default: nxt = fs1 ? IDLE : RELEASE;
    endcase
  end
  assign cnt_up = (cnt == MAX_V) ? (WRAP ? MIN_V : MAX_V) : cnt + 1'b1;
  assign cnt_dn = (cnt == MIN_V) ? (WRAP ? MAX_V : MIN_V) : cnt - 1'b1;
  assign key_level = ~kd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= MIN_V;
      step_cw   <= 1'b0;
      step_ccw  <= 1'b0;
      key_press <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= clr ? MIN_V : cw ? cnt_up : ccw ? cnt_dn : cnt;
      step_cw   <= cw;
      step_ccw  <= ccw;
      key_press <= kd_flip & kd;
    end
endmodule

// File: doc/rotary_encoder_ctrl.md
Name: rotary_encoder_ctrl

Overview:
- Parametrised decoder for a mechanical rotary encoder (channels s1/s2) with push-key.
- Synchronises and glitch-filters all raw inputs, then decodes one count per full detent cycle, signed by direction.
- Keeps a bounded position counter with selectable wrap or saturate at the limits; outputs step and key-press pulses for the menu/display logic.

Parameters:
- CNT_W, 8, position counter width in bits.
- CNT_MIN, 0, lower counter bound; also the reset and clear value.
- CNT_MAX, 255, upper counter bound. Legal only if CNT_MIN < CNT_MAX <= 2^CNT_W-1.
- WRAP, 1, limit mode. 1 = wrap MAX->MIN and MIN->MAX. 0 = saturate at the bound.
- FILT_LEN, 4, number of consecutive differing samples (>=1) needed to accept a new s1/s2 level.
- KEY_DB, 16, number of consecutive differing samples (>=1) needed to accept a new key level.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- s1  in  1  raw encoder channel A, idle high.
- s2  in  1  raw encoder channel B, idle high.
- key  in  1  raw push key, active-low (0 = pressed).
- clr  in  1  synchronous clear; sets cnt to CNT_MIN.
- cnt  out  CNT_W  current position.
- step_cw  out  1  one-cycle pulse on each clockwise detent.
- step_ccw  out  1  one-cycle pulse on each counter-clockwise detent.
- key_level  out  1  debounced key state, 1 = pressed.
- key_press  out  1  one-cycle pulse on the debounced press edge.

Behaviour:
- Reset (async, rst=1):
  - sync flops = 1; filtered s1/s2 = 1; debounced key raw level = 1.
  - filter counters = 0; FSM = IDLE.
  - cnt = CNT_MIN; step_cw = step_ccw = key_level = key_press = 0.
- Synchroniser: 2-flop chain per input. A raw change sampled at edge k is visible at the synchroniser output after edge k+1.
- Filter (independent for s1, s2, key):
  - If sync != filtered, increment the counter. When the counter reaches LEN-1 and the inputs still differ, update filtered and zero the counter. Filtered therefore changes on the LEN-th consecutive differing edge.
  - If sync == filtered, zero the counter.
  - LEN = FILT_LEN for s1/s2, KEY_DB for key.
  - A pulse shorter than LEN cycles has no effect.
- Decoder FSM (on filtered fs1, fs2):
  - IDLE -> ARMED unconditionally.
  - ARMED: stay while fs2=1; go to DETECT when fs2=0.
  - DETECT: wait while fs2=0. On fs2=1:
    - fs1=0 -> clockwise: step_cw=1, cnt+1.
    - fs1=1 -> counter-clockwise: step_ccw=1, cnt-1.
    - Either case -> RELEASE.
  - RELEASE: go to IDLE when fs1=1; otherwise stay.
  - Exactly one count per detent. step_cw and step_ccw are never both 1.
- Latency: a raw s2 rise completing a detent updates cnt and the step pulse on edge FILT_LEN+3 after the first edge that samples the new level. Both are registered and change together.
- Counter arithmetic:
  - CW at CNT_MAX: goes to CNT_MIN if WRAP=1, otherwise holds CNT_MAX.
  - CCW at CNT_MIN: goes to CNT_MAX if WRAP=1, otherwise holds CNT_MIN.
  - The step pulse is asserted even when saturation holds cnt.
  - There is no unsigned underflow outside [CNT_MIN, CNT_MAX].
- clr: cnt <= CNT_MIN on the next edge. It has priority over a simultaneous step; that step's pulse is still emitted. The FSM is unaffected.
- Key outputs: key_level = ~debounced key raw level. key_press = 1 for one cycle on the edge where key_level goes 0->1. There is no release pulse.
- rst mid-detent: everything returns to reset values. The partial detent is discarded, and the next complete detent counts once.

Test Plan:
1. Reset: s1=s2=key=1, rst pulse -> cnt=0, step_cw=step_ccw=0, key_level=0, key_press=0.
2. CW detent, defaults: s2=0, s1=0, s2=1, s1=1, each level held 20 cycles -> cnt 0->1; step_cw high exactly 1 cycle, 7 cycles after the raw s2 rise; step_ccw stays 0.
3. CCW detent at bound: s2=0, s2=1 with s1=1, then s1=1 held. With WRAP=1 -> cnt 0->255 and step_ccw pulses once. With WRAP=0 -> cnt stays 0 and step_ccw still pulses once.
4. Glitch rejection: from idle, s2=0 for 3 cycles (< FILT_LEN=4), then 1; repeat 5 times -> FSM never reaches DETECT, cnt unchanged, no step pulses.
5. Key bounce: key toggles every 2 cycles for 12 cycles, then held 0 for 30 cycles -> exactly one key_press; key_level=1 from 18 cycles after the final edge (KEY_DB=16 plus 2 sync cycles); release bounce produces no pulse.
6. clr and mid-detent reset:
   - clr asserted in the same cycle as a CW step with cnt=9 -> cnt=0 and step_cw pulses.
   - rst asserted during DETECT, then one full CW detent -> cnt=1.
